// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if
//   Groups the configuration, input-beat handshake and result handshake of
//   the MAC accumulator. Clock and reset stay outside as plain module ports.
//
//   cfg_len    window length minus 1, sampled on a window's first beat
//   cfg_shift  right shift applied to the window sum, sampled with cfg_len
//   flush      synchronous abort of the window in progress
//   in_valid / in_ready / in_prod     product beat handshake
//   out_valid / out_ready / out_sum / out_sat   result handshake
//   win_cnt    number of results delivered, wraps at 16 bits
//
//   master: upstream/downstream side (drives beats, config, out_ready)
//   slave : the accumulator itself
interface mac_accumulator_if #(
    parameter int PROD_W = 32,
    parameter int LEN_W  = 8,
    parameter int OUT_W  = 32
);
    logic [LEN_W-1:0]  cfg_len;
    logic [5:0]        cfg_shift;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_sum;
    logic              out_sat;
    logic [15:0]       win_cnt;

    modport master (
        output cfg_len, cfg_shift, flush, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_sat, win_cnt
    );

    modport slave (
        input  cfg_len, cfg_shift, flush, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_sat, win_cnt
    );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator
//   Streaming multiply-accumulate back end. Sums a programmable-length window
//   of unsigned products, right-shifts the sum, saturates it to OUT_W bits and
//   presents one result per window through a valid/ready handshake.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mac_accumulator_if.slave (config, input beats, results, win_cnt)
module mac_accumulator #(
    parameter int PROD_W = 32,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = PROD_W + LEN_W,
    parameter int OUT_W  = 32
) (
    input logic               clk,
    input logic               rst_n,
    mac_accumulator_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    localparam logic [6:0] ACC_W_SH = 7'(ACC_W);

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [LEN_W:0]    cnt;
    logic [LEN_W-1:0]  len_q;
    logic [5:0]        shift_q;
    logic [OUT_W-1:0]  out_sum_q;
    logic              out_sat_q;
    logic [15:0]       win_cnt_q;

    logic              accept;
    logic              last_beat;
    logic [ACC_W-1:0]  acc_next;
    logic [5:0]        shift_sel;
    logic [OUT_W:0]    res_next;

    // Rescale then clip: returns {sat, sum}. Shifts at or beyond the
    // accumulator width give zero rather than relying on shift semantics.
    function automatic logic [OUT_W:0] rescale_sat(
        input logic [ACC_W-1:0] sum,
        input logic [5:0]       sh
    );
        logic [ACC_W-1:0] s;
        if ({1'b0, sh} >= ACC_W_SH) s = '0;
        else                        s = sum >> sh;
        if (|s[ACC_W-1:OUT_W]) return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, s[OUT_W-1:0]};
    endfunction

    assign bus.in_ready = (state != OUT) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;

    // acc is zero in IDLE, so the same adder serves the first beat.
    assign acc_next  = acc + ACC_W'(bus.in_prod);

    // On the first beat the window length comes straight from cfg_len,
    // later beats compare the pre-increment count against the latched length.
    assign last_beat = (state == IDLE) ? (bus.cfg_len == '0)
                                       : (cnt == {1'b0, len_q});
    assign shift_sel = (state == IDLE) ? bus.cfg_shift : shift_q;
    assign res_next  = rescale_sat(acc_next, shift_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            out_sum_q <= '0;
            out_sat_q <= 1'b0;
            win_cnt_q <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (bus.flush) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (accept) begin
                        if (state == IDLE) begin
                            len_q   <= bus.cfg_len;
                            shift_q <= bus.cfg_shift;
                        end
                        acc <= acc_next;
                        cnt <= cnt + (LEN_W+1)'(1);
                        if (last_beat) begin
                            state                  <= OUT;
                            {out_sat_q, out_sum_q} <= res_next;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                OUT: begin
                    // flush is deliberately ignored here: the result is kept.
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        win_cnt_q <= win_cnt_q + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = (state == OUT);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.win_cnt   = win_cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator
//   Self-checking bench for mac_accumulator. A behavioural model collects the
//   accepted beats of each window in a queue, computes the shifted, clipped
//   sum with plain arithmetic and pushes it to a scoreboard; a monitor pops
//   and compares whenever the DUT presents a result.
module tb_mac_accumulator;

    logic clk;
    logic rst_n;

    mac_accumulator_if #(.PROD_W(32), .LEN_W(8), .OUT_W(32)) bus ();

    mac_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] sum;
        logic        sat;
    } res_t;

    logic [31:0] beats[$];
    res_t        exp_q[$];
    logic [7:0]  m_len   = '0;
    logic [5:0]  m_shift = '0;
    bit          m_pending = 1'b0;
    logic [15:0] m_wins    = '0;

    function automatic res_t window_result();
        longint unsigned total = 0;
        longint unsigned s;
        res_t r;
        foreach (beats[i]) total += beats[i];
        s = (m_shift >= 40) ? 64'd0 : (total >> m_shift);
        if (s > 64'hFFFF_FFFF) begin
            r.sum = 32'hFFFF_FFFF;
            r.sat = 1'b1;
        end else begin
            r.sum = s[31:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats.delete();
            exp_q.delete();
            m_pending = 1'b0;
            m_wins    = '0;
        end else if (m_pending) begin
            if (bus.out_ready) begin
                m_pending = 1'b0;
                m_wins    = m_wins + 16'd1;
            end
        end else if (bus.flush) begin
            beats.delete();
        end else if (bus.in_valid) begin
            if (beats.size() == 0) begin
                m_len   = bus.cfg_len;
                m_shift = bus.cfg_shift;
            end
            beats.push_back(bus.in_prod);
            if (beats.size() == int'(m_len) + 1) begin
                exp_q.push_back(window_result());
                beats.delete();
                m_pending = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready",  {63'd0, bus.in_ready},  {63'd0, (!m_pending && !bus.flush)});
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_pending});
            chk("win_cnt",   {48'd0, bus.win_cnt},   {48'd0, m_wins});
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result_sum", {32'd0, bus.out_sum}, 64'hDEAD_0000_0000);
                end else begin
                    chk("out_sum", {32'd0, bus.out_sum}, {32'd0, exp_q[0].sum});
                    chk("out_sat", {63'd0, bus.out_sat}, {63'd0, exp_q[0].sat});
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] p);
        bit ok = 1'b0;
        bit rdy;
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        for (int i = 0; i < 64; i++) begin
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: beat 0x%0h never accepted", p);
        end
    endtask

    task automatic expect_now(input string name, input logic [31:0] s, input logic sat);
        @(negedge clk);
        chk({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk({name, "_sum"},   {32'd0, bus.out_sum},   {32'd0, s});
        chk({name, "_sat"},   {63'd0, bus.out_sat},   {63'd0, sat});
        @(posedge clk); #1;
    endtask

    task automatic async_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        chk({name, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({name, "_out_sum"},   {32'd0, bus.out_sum},   64'd0);
        chk({name, "_out_sat"},   {63'd0, bus.out_sat},   64'd0);
        chk({name, "_win_cnt"},   {48'd0, bus.win_cnt},   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !m_pending) break;
            @(posedge clk); #1;
        end
        chk({name, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        bus.cfg_len   = '0;
        bus.cfg_shift = '0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_out_sum",   {32'd0, bus.out_sum},   64'd0);
        chk("reset_out_sat",   {63'd0, bus.out_sat},   64'd0);
        chk("reset_win_cnt",   {48'd0, bus.win_cnt},   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // basic 9-beat window
        bus.cfg_len = 8'd8;
        bus.cfg_shift = 6'd0;
        for (int i = 1; i <= 9; i++) send(32'(i));
        bus.in_valid = 1'b0;
        expect_now("basic", 32'd45, 1'b0);
        chk("basic_win_cnt", {48'd0, bus.win_cnt}, 64'd1);

        // saturation and shift
        bus.cfg_len = 8'd3;
        bus.cfg_shift = 6'd0;
        repeat (4) send(32'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        expect_now("sat_sh0", 32'hFFFF_FFFF, 1'b1);
        bus.cfg_shift = 6'd2;
        repeat (4) send(32'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        expect_now("sat_sh2", 32'hFFFF_FFFF, 1'b0);
        bus.cfg_shift = 6'd3;
        repeat (4) send(32'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        expect_now("sat_sh3", 32'h7FFF_FFFF, 1'b0);
        bus.cfg_shift = 6'd0;

        // backpressure with in_valid held high
        bus.cfg_len = 8'd2;
        bus.out_ready = 1'b0;
        send(32'd100);
        send(32'd200);
        send(32'd300);
        bus.in_prod = 32'd500;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_hold_sum", {32'd0, bus.out_sum},  64'd600);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        send(32'd500);
        send(32'd600);
        send(32'd700);
        bus.in_valid = 1'b0;
        expect_now("bp_next", 32'd1800, 1'b0);

        // flush mid-window, with a competing beat
        bus.cfg_len = 8'd8;
        repeat (3) send(32'd100);
        bus.in_prod = 32'd999;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.cfg_len = 8'd1;
        send(32'd10);
        send(32'd20);
        bus.in_valid = 1'b0;
        expect_now("flush_next", 32'd30, 1'b0);

        // flush while a result is held
        bus.cfg_len = 8'd0;
        bus.out_ready = 1'b0;
        send(32'd55);
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        expect_now("flush_in_out", 32'd55, 1'b0);

        // length-1 windows streamed
        bus.cfg_len = 8'd0;
        send(32'd7);
        send(32'd8);
        send(32'd9);
        bus.in_valid = 1'b0;
        drain("len1");

        // cfg_len toggled inside a 4-beat window
        bus.cfg_len = 8'd3;
        send(32'd1);
        bus.cfg_len = 8'd0;
        send(32'd2);
        bus.cfg_len = 8'd7;
        send(32'd3);
        bus.cfg_len = 8'd1;
        send(32'd4);
        bus.in_valid = 1'b0;
        bus.cfg_len = 8'd0;
        expect_now("cfg_change", 32'd10, 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_prod   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.cfg_len   = 8'($urandom_range(0, 6));
            bus.cfg_shift = 6'($urandom_range(0, 45));
            @(posedge clk); #1;
        end
        bus.cfg_shift = 6'd0;
        drain("random");

        // asynchronous reset mid-window
        bus.cfg_len = 8'd5;
        send(32'd3);
        send(32'd3);
        bus.in_valid = 1'b0;
        async_reset("rst_accum");

        // asynchronous reset while a result is held
        bus.cfg_len = 8'd0;
        bus.out_ready = 1'b0;
        send(32'd77);
        bus.in_valid = 1'b0;
        async_reset("rst_out");
        bus.out_ready = 1'b1;

        // first window after reset
        @(posedge clk); #1;
        bus.cfg_len = 8'd2;
        send(32'd5);
        send(32'd6);
        send(32'd7);
        bus.in_valid = 1'b0;
        expect_now("post_reset", 32'd18, 1'b0);
        chk("post_reset_win_cnt", {48'd0, bus.win_cnt}, 64'd1);
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Streaming multiply-accumulate back end for the approximate CNN datapath. It sits directly downstream of the 16x16 Wallace multiplier and consumes its 32-bit unsigned products one per cycle through a valid/ready handshake. It sums a programmable-length window of products (one convolution window, e.g. 9 for a 3x3 kernel) and rescales the sum with a right shift. It then emits one saturated result per window toward the activation/pooling stage.

## Interface
- PROD_W, 32, product width; matches the multiplier `sum` output
- LEN_W, 8, window-length field width; window length range is 1..2^LEN_W
- ACC_W, PROD_W+LEN_W, accumulator width; guarantees the accumulator never overflows
- OUT_W, 32, result width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- cfg_len  in  LEN_W  window length minus 1; latched on the first beat of each window
- cfg_shift  in  6  right-shift amount applied to the sum; latched together with cfg_len
- flush  in  1  synchronous abort of the current window
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat
- in_prod  in  PROD_W  product from the multiplier
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  OUT_W  rescaled, saturated window sum
- out_sat  out  1  out_sum was clipped
- win_cnt  out  16  count of results delivered (out_valid && out_ready); wraps 0xFFFF->0

## Operation
- States:
  - IDLE: acc=0, cnt=0.
  - ACCUM: window in progress.
  - OUT: result held.
- in_ready = (state != OUT) && !flush.
- A beat is accepted when in_valid && in_ready.
- IDLE, on an accepted beat:
  - latch len_q=cfg_len and shift_q=cfg_shift.
  - acc=in_prod, cnt=1.
  - go to ACCUM, or go straight to OUT if cfg_len==0.
- ACCUM, on an accepted beat:
  - acc+=in_prod, cnt+=1.
  - when the beat is number len_q+1, go to OUT.
  - with no beat, hold all state.
- On the transition into OUT:
  - compute s = (acc_next >> shift_q), zero-extended to ACC_W.
  - if s > 2^OUT_W-1: out_sum=all ones, out_sat=1.
  - else: out_sum=s[OUT_W-1:0], out_sat=0.
  - out_sum and out_sat are registered.
- OUT:
  - out_valid=1; out_sum and out_sat are stable until the handshake.
  - on out_ready: go to IDLE, increment win_cnt, clear acc and cnt.
- cfg_len and cfg_shift changes mid-window have no effect until the next window's first beat.
- flush:
  - IDLE/ACCUM: go to IDLE next cycle, discard acc; no beat is accepted that cycle, since flush wins over in_valid.
  - OUT: ignored; the pending result is still delivered.
- Arithmetic: unsigned only, no wrap in acc. shift_q >= ACC_W yields 0.

## Timing
- Reset values: state=IDLE, in_ready=1 after rst_n deasserts, out_valid=0, out_sum=0, out_sat=0, win_cnt=0, acc=0.
- Asserting rst_n mid-window or mid-OUT clears everything immediately, regardless of clk.
- Latency: the last beat is accepted in cycle t; out_valid=1 in cycle t+1.
- Throughput: one beat per cycle within a window. in_ready=0 for every cycle in OUT, so at minimum one bubble per window.
- With out_ready held high, a window of length L occupies L+1 cycles.
- Backpressure: out_valid stays high and out_sum/out_sat stay stable while out_ready=0. No input beat is lost, because none is accepted.
- A flush in the same cycle as an accepted-eligible beat: the beat is not accepted (in_ready=0).

## Test plan
- Basic window: cfg_len=8, cfg_shift=0, products 1..9 back-to-back, out_ready=1.
  - out_valid one cycle after the 9th beat, out_sum=45, out_sat=0, win_cnt=1.
- Saturation: cfg_len=3, four beats of 0xFFFFFFFF.
  - shift=0: out_sum=0xFFFFFFFF, out_sat=1.
  - repeated with shift=2: out_sum=0xFFFFFFFF, out_sat=0; shift=3: out_sum=0x7FFFFFFF.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 continuously.
  - out_valid, out_sum and out_sat stay stable; in_ready=0.
  - after release, the next window's sum excludes no beats and double-counts none.
- Flush: flush after 3 beats of 100.
  - no output.
  - next window cfg_len=1 with products 10, 20 gives out_sum=30.
  - flush asserted during OUT leaves the result intact.
- Length 1 and config change: cfg_len=0, products 7, 8, 9 streamed.
  - out_sum 7, 8, 9 on alternating cycles.
  - toggling cfg_len mid-window in a length-4 window does not change its length.
- Reset mid-operation: rst_n low during ACCUM and again during OUT.
  - out_valid=0, out_sum=0, win_cnt=0 immediately.
  - the first window after reset sums correctly.
